ifft_frame_sched: RTL and testbench

Frame-level scheduler that shares one `ifftm16` instance between two complex sample sources. It grants the IFFT input to one source for exactly one NFFT-sample frame at a time, round-robin. It generates `tlast` on the frame's final beat and inserts a programmable idle gap between frames. It also limits the number of frames in flight inside the IFFT using credits returned from the IFFT output stream. It sits directly in front of `ifftm16` in the TX chain.

---
 rtl/ifft_sched_pkg.sv | 21 ++
 rtl/ifft_credit_cnt.sv | 41 ++++
 rtl/ifft_frame_sched.sv | 179 +++++++++++++++++
 tb/tb_ifft_frame_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_sched_pkg.sv
// rtl/ifft_sched_pkg.sv - state encoding, widths and arbitration helper for the IFFT frame scheduler
package ifft_sched_pkg;

   localparam int INFLIGHT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2,
      GAP  = 2'd3
   } sched_state_e;

   // Winner of a two-way request; pref names the source favoured when both request.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic pref);
      if (req0 && req1) begin
         return pref;
      end
      return req1;
   endfunction

endpackage

// File: rtl/ifft_credit_cnt.sv
// rtl/ifft_credit_cnt.sv - saturating in-flight frame counter; coincident return and issue cancel out
module ifft_credit_cnt
   import ifft_sched_pkg::*;
#(
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  inc_i,
   input  logic                  dec_i,
   output logic [INFLIGHT_W-1:0] inflight_o,
   output logic                  credit_ok_o
);

   localparam logic [INFLIGHT_W-1:0] MAX_CNT = INFLIGHT_W'(MAX_INFLIGHT);
   localparam logic [INFLIGHT_W-1:0] ONE     = INFLIGHT_W'(1);

   logic [INFLIGHT_W-1:0] cnt_q;
   logic [INFLIGHT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && (cnt_q != MAX_CNT)) begin
         cnt_d = cnt_q + ONE;
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign inflight_o  = cnt_q;
   assign credit_ok_o = (cnt_q < MAX_CNT);

endmodule

// File: rtl/ifft_frame_sched.sv
// rtl/ifft_frame_sched.sv - round-robin frame scheduler sharing one IFFT between two sources
// Optional statistics counters are enabled with IFFT_SCHED_STATS_EN.
module ifft_frame_sched
   import ifft_sched_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int NFFT         = 512,
   parameter int GAP_WIDTH    = 16,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cfg_enable,
   input  logic [GAP_WIDTH-1:0]  cfg_gap,
   input  logic                  s0_tvalid,
   output logic                  s0_tready,
   input  logic [DATA_WIDTH-1:0] s0_itdata,
   input  logic [DATA_WIDTH-1:0] s0_qtdata,
   input  logic                  s1_tvalid,
   output logic                  s1_tready,
   input  logic [DATA_WIDTH-1:0] s1_itdata,
   input  logic [DATA_WIDTH-1:0] s1_qtdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [DATA_WIDTH-1:0] m_itdata,
   output logic [DATA_WIDTH-1:0] m_qtdata,
   input  logic                  fft_out_tvalid,
   input  logic                  fft_out_tready,
   input  logic                  fft_out_tlast,
   output logic                  grant,
   output logic                  busy,
`ifdef IFFT_SCHED_STATS_EN
   output logic [31:0]           stat_frames0,
   output logic [31:0]           stat_frames1,
   output logic [31:0]           stat_credit_stall,
`endif
   output logic [INFLIGHT_W-1:0] inflight
);

   localparam int                   CNT_W     = $clog2(NFFT);
   localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(NFFT - 1);
   localparam logic [CNT_W-1:0]     BEAT_ONE  = CNT_W'(1);
   localparam logic [GAP_WIDTH-1:0] GAP_ONE   = GAP_WIDTH'(1);

   sched_state_e         state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 rr_pref_q, rr_pref_d;
   logic [CNT_W-1:0]     beat_q, beat_d;
   logic [GAP_WIDTH-1:0] gap_q, gap_d;

   logic req_any;
   logic pick;
   logic in_xfer;
   logic sel_tvalid;
   logic beat_fire;
   logic last_fire;
   logic credit_ret;
   logic credit_ok;

   assign req_any    = s0_tvalid | s1_tvalid;
   assign pick       = rr_pick(s0_tvalid, s1_tvalid, rr_pref_q);
   assign in_xfer    = (state_q == XFER);
   assign sel_tvalid = grant_q ? s1_tvalid : s0_tvalid;
   assign credit_ret = fft_out_tvalid & fft_out_tready & fft_out_tlast;

   // Zero-latency path: the selected source sees the IFFT's ready directly.
   assign m_tvalid  = in_xfer & sel_tvalid;
   assign s0_tready = in_xfer & ~grant_q & m_tready;
   assign s1_tready = in_xfer &  grant_q & m_tready;
   assign m_itdata  = grant_q ? s1_itdata : s0_itdata;
   assign m_qtdata  = grant_q ? s1_qtdata : s0_qtdata;
   assign m_tlast   = m_tvalid & (beat_q == LAST_BEAT);
   assign beat_fire = m_tvalid & m_tready;
   assign last_fire = beat_fire & (beat_q == LAST_BEAT);

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

   ifft_credit_cnt #(
      .MAX_INFLIGHT(MAX_INFLIGHT)
   ) u_credit (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (last_fire),
      .dec_i      (credit_ret),
      .inflight_o (inflight),
      .credit_ok_o(credit_ok)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_pref_d = rr_pref_q;
      beat_d    = beat_q;
      gap_d     = gap_q;
      case (state_q)
         IDLE: begin
            if (cfg_enable) begin
               state_d = ARB;
            end
         end
         ARB: begin
            if (!cfg_enable) begin
               state_d = IDLE;
            end else if (credit_ok && req_any) begin
               grant_d   = pick;
               rr_pref_d = ~pick;
               state_d   = XFER;
            end
         end
         XFER: begin
            if (last_fire) begin
               beat_d  = '0;
               gap_d   = cfg_gap;
               state_d = (cfg_gap == '0) ? ARB : GAP;
            end else if (beat_fire) begin
               beat_d = beat_q + BEAT_ONE;
            end
         end
         GAP: begin
            // A gap of G leaves exactly G cycles in this state.
            if (gap_q <= GAP_ONE) begin
               state_d = ARB;
            end else begin
               gap_d = gap_q - GAP_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         rr_pref_q <= 1'b0;
         beat_q    <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_pref_q <= rr_pref_d;
         beat_q    <= beat_d;
         gap_q     <= gap_d;
      end
   end

`ifdef IFFT_SCHED_STATS_EN
   logic [31:0] frames0_q;
   logic [31:0] frames1_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frames0_q <= '0;
         frames1_q <= '0;
         stall_q   <= '0;
      end else begin
         if (last_fire && !grant_q) begin
            frames0_q <= frames0_q + 32'd1;
         end
         if (last_fire && grant_q) begin
            frames1_q <= frames1_q + 32'd1;
         end
         if ((state_q == ARB) && req_any && !credit_ok) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign stat_frames0      = frames0_q;
   assign stat_frames1      = frames1_q;
   assign stat_credit_stall = stall_q;
`endif

endmodule

// File: tb/tb_ifft_frame_sched.sv
// tb/tb_ifft_frame_sched.sv - self-checking bench for ifft_frame_sched with a frame-level reference model
`timescale 1ns/1ps
module tb_ifft_frame_sched;

   localparam int DW   = 16;
   localparam int NFFT = 512;
   localparam int GW   = 16;
   localparam int MAXF = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cfg_enable;
   logic [GW-1:0] cfg_gap;
   logic          s0_tvalid, s0_tready, s1_tvalid, s1_tready;
   logic [DW-1:0] s0_itdata, s0_qtdata, s1_itdata, s1_qtdata;
   logic          m_tvalid, m_tready, m_tlast;
   logic [DW-1:0] m_itdata, m_qtdata;
   logic          fft_out_tvalid, fft_out_tready, fft_out_tlast;
   logic          grant, busy;
   logic [2:0]    inflight;

   always #5 clk = ~clk;

   ifft_frame_sched #(
      .DATA_WIDTH(DW), .NFFT(NFFT), .GAP_WIDTH(GW), .MAX_INFLIGHT(MAXF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_gap(cfg_gap),
      .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_itdata(s0_itdata), .s0_qtdata(s0_qtdata),
      .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_itdata(s1_itdata), .s1_qtdata(s1_qtdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_itdata(m_itdata), .m_qtdata(m_qtdata),
      .fft_out_tvalid(fft_out_tvalid), .fft_out_tready(fft_out_tready), .fft_out_tlast(fft_out_tlast),
      .grant(grant), .busy(busy), .inflight(inflight)
   );

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic logic [DW-1:0] sample(int src, int s);
      return DW'((src << 15) | (s & 32'h7fff));
   endfunction

   // Stimulus state
   int  seq [2];
   int  cyc_drv = 0;
   bit  rand_ready = 0;
   bit  ret_en = 0;
   int  ret_delay = 600;
   bit  manual_ret = 0;
   int  ret_q [$];

   // Reference model state
   int  cyc = 0;
   int  m_idx, m_inf, m_src, m_last_src, m_gap_lat, last_end, last_idle, frames_done;
   int  m_seq [2];
   bit  gap_chk = 0;
   int  hist [$];
   bit  mhs, h0, h1, dec, inc;
   logic [DW-1:0] exp_i, exp_q;

   always @(negedge clk) begin
      mhs = m_tvalid & m_tready;
      h0  = s0_tvalid & s0_tready;
      h1  = s1_tvalid & s1_tready;
      dec = fft_out_tvalid & fft_out_tready & fft_out_tlast;
      inc = 1'b0;
      if (!reset_n) begin
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_m_tlast", m_tlast, 0);
         chk("rst_s0_tready", s0_tready, 0);
         chk("rst_s1_tready", s1_tready, 0);
         chk("rst_grant", grant, 0);
         chk("rst_busy", busy, 0);
         chk("rst_inflight", inflight, 0);
         m_idx = 0; m_inf = 0; m_last_src = 1; last_end = -1; frames_done = 0;
      end else begin
         chk("inflight", inflight, m_inf);
         if (mhs) begin
            if (m_idx == 0) begin
               if (s0_tvalid && s1_tvalid) m_src = 1 - m_last_src;
               else m_src = s1_tvalid ? 1 : 0;
               hist.push_back(m_src);
               if (gap_chk && last_end >= 0) begin
                  last_idle = cyc - last_end - 1;
                  chk("idle_cycles", last_idle, m_gap_lat + 1);
               end
            end
            exp_i = sample(m_src, m_seq[m_src]);
            exp_q = ~exp_i;
            chk("grant", grant, m_src);
            chk("m_itdata", m_itdata, exp_i);
            chk("m_qtdata", m_qtdata, exp_q);
            chk("sel_handshake", (m_src == 1) ? h1 : h0, 1);
            chk("other_quiet", (m_src == 1) ? h0 : h1, 0);
            chk("m_tlast", m_tlast, m_idx == NFFT - 1);
            m_seq[m_src]++;
            m_idx++;
            if (m_idx == NFFT) begin
               m_idx = 0; inc = 1'b1; frames_done++;
               m_last_src = m_src; m_gap_lat = int'(cfg_gap); last_end = cyc;
            end
         end else begin
            chk("no_stray_beat", h0 | h1, 0);
            chk("m_tlast_stalled", m_tlast, m_tvalid && (m_idx == NFFT - 1));
         end
         if (inc && !dec) m_inf = (m_inf < MAXF) ? m_inf + 1 : MAXF;
         else if (dec && !inc) m_inf = (m_inf > 0) ? m_inf - 1 : 0;
      end
      cyc++;
   end

   task automatic drive_src();
      s0_itdata = sample(0, seq[0]); s0_qtdata = ~sample(0, seq[0]);
      s1_itdata = sample(1, seq[1]); s1_qtdata = ~sample(1, seq[1]);
   endtask

   task automatic step();
      bit a0, a1, ret;
      @(negedge clk);
      a0 = s0_tvalid & s0_tready;
      a1 = s1_tvalid & s1_tready;
      if (ret_en && m_tvalid && m_tready && m_tlast) ret_q.push_back(cyc_drv + ret_delay);
      @(posedge clk); #1;
      cyc_drv++;
      if (a0) seq[0]++;
      if (a1) seq[1]++;
      drive_src();
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
      ret = manual_ret;
      manual_ret = 1'b0;
      if (ret_q.size() > 0 && ret_q[0] <= cyc_drv) begin
         ret = 1'b1;
         void'(ret_q.pop_front());
      end
      fft_out_tvalid = ret; fft_out_tready = ret; fft_out_tlast = ret;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cfg_enable = 1'b0;
      ret_q.delete();
      repeat (3) step();
      reset_n = 1'b1;
      step();
      hist.delete();
   endtask

   task automatic wait_frames(int target, int budget, string name);
      int n = 0;
      while (frames_done < target && n < budget) begin step(); n++; end
      if (frames_done < target) chk({"timeout_", name}, frames_done, target);
   endtask

   task automatic wait_beat(int idx, int budget, string name);
      int n = 0;
      while (m_idx != idx && n < budget) begin step(); n++; end
      if (m_idx != idx) chk({"timeout_", name}, m_idx, idx);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int k, s_start, zeros;
      reset_n = 1'b0; cfg_enable = 1'b0; cfg_gap = '0;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
      fft_out_tvalid = 1'b0; fft_out_tready = 1'b0; fft_out_tlast = 1'b0;
      seq[0] = 0; seq[1] = 0;
      drive_src();

      // Single source, long gap, credits returned 600 cycles after each frame
      cfg_gap = 16'd100; s0_tvalid = 1'b1; ret_en = 1; ret_delay = 600; gap_chk = 1;
      do_reset();
      manual_ret = 1'b1; step();
      manual_ret = 1'b1; step();
      step();
      chk("credit_floor_zero", inflight, 0);
      chk("idle_not_busy", busy, 0);
      cfg_enable = 1'b1;
      wait_frames(3, 3000, "t1");
      zeros = 0;
      foreach (hist[i]) if (hist[i] == 0) zeros++;
      chk("t1_frames_from_s0", zeros, 3);
      chk("t1_idle_gap", last_idle, 101);

      // Both sources, zero gap: strict alternation starting with source 0
      cfg_gap = 16'd0; s1_tvalid = 1'b1; ret_delay = 10;
      do_reset();
      cfg_enable = 1'b1;
      wait_frames(4, 2600, "t2");
      chk("t2_grant0", hist[0], 0);
      chk("t2_grant1", hist[1], 1);
      chk("t2_grant2", hist[2], 0);
      chk("t2_grant3", hist[3], 1);
      chk("t2_idle_gap", last_idle, 1);

      // No credit return: stalls in ARB after MAX_INFLIGHT frames
      cfg_gap = 16'd4; s1_tvalid = 1'b0; ret_en = 0; gap_chk = 0;
      do_reset();
      cfg_enable = 1'b1;
      wait_frames(2, 1400, "t3");
      repeat (40) step();
      chk("t3_inflight_full", inflight, 2);
      chk("t3_stalled_tvalid", m_tvalid, 0);
      chk("t3_stalled_busy", busy, 1);
      chk("t3_no_third_frame", frames_done, 2);
      manual_ret = 1'b1;
      k = 0;
      do begin step(); k++; end while (!m_tvalid && k < 10);
      chk("t3_restart_within_2", (k - 1) <= 2, 1);
      wait_frames(3, 700, "t3b");

      // Random backpressure: exactly 512 beats per frame
      cfg_gap = 16'd3; ret_en = 1; ret_delay = 20; rand_ready = 1;
      do_reset();
      s_start = seq[0];
      cfg_enable = 1'b1;
      wait_frames(2, 3500, "t4");
      chk("t4_beats_two_frames", seq[0] - s_start, 1024);
      rand_ready = 0; m_tready = 1'b1;

      // Enable dropped mid-frame: frame completes, then idle
      cfg_gap = 16'd5;
      do_reset();
      cfg_enable = 1'b1;
      wait_beat(200, 400, "t5_beat");
      cfg_enable = 1'b0;
      wait_frames(1, 700, "t5");
      repeat (20) step();
      chk("t5_busy_low", busy, 0);
      chk("t5_tvalid_low", m_tvalid, 0);
      repeat (100) step();
      chk("t5_no_new_frame", frames_done, 1);

      // Reset mid-frame
      cfg_gap = 16'd2; ret_en = 0;
      do_reset();
      cfg_enable = 1'b1;
      wait_frames(1, 700, "t6a");
      wait_beat(300, 700, "t6_beat");
      chk("t6_inflight_pre", inflight, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_async_tvalid", m_tvalid, 0);
      chk("t6_async_tlast", m_tlast, 0);
      chk("t6_async_s0_tready", s0_tready, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_inflight", inflight, 0);
      chk("t6_async_grant", grant, 0);
      repeat (3) step();
      reset_n = 1'b1;
      k = 0;
      while (!m_tvalid && k < 20) begin step(); k++; end
      chk("t6_restart_seen", m_tvalid, 1);
      chk("t6_inflight_zero", inflight, 0);
      wait_frames(1, 700, "t6b");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
